// File: rtl/keylime_pkg.sv
// Shared types for the password-manager storage path: command opcodes,
// response status codes and the sequencer state encoding.
package keylime_pkg;

  typedef enum logic [1:0] {
    OP_STORE = 2'b00,
    OP_GET   = 2'b01,
    OP_ERASE = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_EMPTY   = 2'b01,
    ST_UNK_CMD = 2'b10
  } rsp_status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP
  } state_e;

endpackage

// File: rtl/pw_store_ctrl.sv
// Command sequencer between the password-manager FSM and the storage memory:
// serialises passwords into memory beats, tracks slot occupancy, one response per command.
module pw_store_ctrl
  import keylime_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MEM_WIDTH  = 32,
  parameter int unsigned SLOTS      = 16
) (
  input  logic                                                     clk,
  input  logic                                                     rst_n,
  input  logic                                                     cmd_valid,
  output logic                                                     cmd_ready,
  input  logic [1:0]                                               cmd_op,
  input  logic [$clog2(SLOTS)-1:0]                                 cmd_slot,
  input  logic [DATA_WIDTH-1:0]                                    cmd_data,
  output logic                                                     rsp_valid,
  input  logic                                                     rsp_ready,
  output logic [1:0]                                               rsp_status,
  output logic [DATA_WIDTH-1:0]                                    rsp_data,
  output logic                                                     mem_req,
  output logic                                                     mem_we,
  output logic [$clog2(SLOTS)+$clog2(DATA_WIDTH/MEM_WIDTH)-1:0]    mem_addr,
  output logic [MEM_WIDTH-1:0]                                     mem_wdata,
  input  logic                                                     mem_gnt,
  input  logic                                                     mem_rvalid,
  input  logic [MEM_WIDTH-1:0]                                     mem_rdata
);

  localparam int unsigned BEATS = DATA_WIDTH / MEM_WIDTH;
  localparam int unsigned SW    = $clog2(SLOTS);
  localparam int unsigned BW    = $clog2(BEATS);
  localparam int unsigned CW    = BW + 1;
  localparam logic [CW-1:0] LAST   = CW'(BEATS - 1);
  localparam logic [CW-1:0] NBEATS = CW'(BEATS);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_e                          state_q, state_d;
  cmd_op_e                         op_in;
  logic [SW-1:0]                   slot_q;
  logic [BEATS-1:0][MEM_WIDTH-1:0] data_q;
  logic [BEATS-1:0][MEM_WIDTH-1:0] asm_q;
  logic [CW-1:0]                   beat_q;
  logic [CW-1:0]                   ret_q;
  logic [SLOTS-1:0]                valid_q;
  rsp_status_e                     status_q;
  logic [BW-1:0]                   beat_idx;
  logic [BW-1:0]                   ret_idx;
  logic                            rd_gnt;
  logic                            rd_ret;

  assign op_in    = cmd_op_e'(cmd_op);
  assign beat_idx = beat_q[BW-1:0];
  assign ret_idx  = ret_q[BW-1:0];
  assign rd_gnt   = (state_q == S_READ) && mem_gnt && (beat_q != NBEATS);
  // A return is only accepted while a granted read is still outstanding.
  assign rd_ret   = (state_q == S_READ) && mem_rvalid && (ret_q != beat_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (op_in)
            OP_STORE: state_d = S_WRITE;
            OP_GET:   state_d = valid_q[cmd_slot] ? S_READ : S_RESP;
            default:  state_d = S_RESP;
          endcase
        end
      end
      S_WRITE: if (mem_gnt && (beat_q == LAST)) state_d = S_RESP;
      S_READ:  if (rd_ret && (ret_q == LAST))   state_d = S_RESP;
      S_RESP:  if (rsp_ready)                   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      data_q   <= '0;
      asm_q    <= '0;
      beat_q   <= '0;
      ret_q    <= '0;
      valid_q  <= '0;
      status_q <= ST_OK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            slot_q <= cmd_slot;
            data_q <= cmd_data;
            asm_q  <= '0;
            beat_q <= '0;
            ret_q  <= '0;
            case (op_in)
              OP_STORE: status_q <= ST_OK;
              OP_GET:   status_q <= valid_q[cmd_slot] ? ST_OK : ST_EMPTY;
              OP_ERASE: begin
                valid_q[cmd_slot] <= 1'b0;
                status_q          <= ST_OK;
              end
              default:  status_q <= ST_UNK_CMD;
            endcase
          end
        end
        S_WRITE: begin
          if (mem_gnt) begin
            beat_q <= beat_q + ONE;
            if (beat_q == LAST) valid_q[slot_q] <= 1'b1;
          end
        end
        S_READ: begin
          if (rd_gnt) beat_q <= beat_q + ONE;
          if (rd_ret) begin
            asm_q[ret_idx] <= mem_rdata;
            ret_q          <= ret_q + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_status = status_q;
  assign rsp_data   = (state_q == S_RESP) ? asm_q : '0;
  assign mem_req    = (state_q == S_WRITE) || ((state_q == S_READ) && (beat_q != NBEATS));
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = {slot_q, beat_idx};
  assign mem_wdata  = mem_we ? data_q[beat_idx] : '0;

endmodule

// File: tb/tb_pw_store_ctrl.sv
// Directed bench for pw_store_ctrl with a behavioural storage memory
// (random grant stalls, 1-3 cycle in-order read latency) and response/write scoreboards.
module tb_pw_store_ctrl;
  import keylime_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [3:0]   cmd_slot;
  logic [127:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_status;
  logic [127:0] rsp_data;
  logic         mem_req;
  logic         mem_we;
  logic [5:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;

  always #5 clk = ~clk;

  pw_store_ctrl #(.DATA_WIDTH(128), .MEM_WIDTH(32), .SLOTS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_slot(cmd_slot), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_data(rsp_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model and monitors ----------------
  typedef struct {logic [5:0] addr; int rdy;} rd_t;
  typedef struct packed {logic [5:0] addr; logic [31:0] data;} wr_t;

  logic [31:0]  mem [0:63];
  rd_t          rd_pend[$];
  wr_t          wr_exp[$];
  logic [129:0] exp_q[$];
  int           cyc = 0;
  int           req_cnt = 0;
  bit           gnt_tied = 1'b1;
  bit           dly_rand = 1'b0;
  logic         stall_pend = 1'b0;
  logic [5:0]   h_addr;
  logic         h_we;
  logic [31:0]  h_wdata;

  always @(posedge clk) begin : mem_side
    int d;
    wr_t w;
    cyc++;
    if (!rst_n) begin
      rd_pend.delete();
      stall_pend = 1'b0;
    end else begin
      if (mem_req) req_cnt++;
      if (stall_pend) begin
        check("stall_addr", mem_addr, h_addr);
        check("stall_we", mem_we, h_we);
        check("stall_wdata", mem_wdata, h_wdata);
      end
      stall_pend = mem_req && !mem_gnt;
      h_addr     = mem_addr;
      h_we       = mem_we;
      h_wdata    = mem_wdata;
      if (mem_rvalid && rd_pend.size() > 0) void'(rd_pend.pop_front());
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          tests++;
          assert (wr_exp.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", mem_addr, mem_wdata);
          end
          if (wr_exp.size() != 0) begin
            w = wr_exp.pop_front();
            check("write_addr", mem_addr, w.addr);
            check("write_data", mem_wdata, w.data);
          end
        end else begin
          d = dly_rand ? int'($urandom_range(1, 3)) : 1;
          rd_pend.push_back('{addr: mem_addr, rdy: cyc + d - 1});
        end
      end
    end
  end

  always @(negedge clk) begin
    mem_gnt = gnt_tied ? 1'b1 : ($urandom_range(0, 99) < 60);
    if (rst_n && rd_pend.size() > 0 && rd_pend[0].rdy <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem[rd_pend[0].addr];
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_reset(input string pfx);
    check({pfx, "_cmd_ready"}, cmd_ready, 1);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_rsp_status"}, rsp_status, 0);
    check({pfx, "_rsp_data"}, rsp_data, 0);
    check({pfx, "_mem_req"}, mem_req, 0);
    check({pfx, "_mem_we"}, mem_we, 0);
    check({pfx, "_mem_addr"}, mem_addr, 0);
    check({pfx, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [3:0] slot, input logic [127:0] data,
                        input logic [1:0] est, input logic [127:0] edata,
                        input int exp_lat, input int hold, input bit no_req);
    logic [129:0] e;
    int n;
    exp_q.push_back({est, edata});
    if (op == 2'b00)
      for (int k = 0; k < 4; k++) wr_exp.push_back('{addr: {slot, k[1:0]}, data: data[32*k +: 32]});
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    req_cnt   = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_slot  = slot;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 500);
    check("rsp_valid", rsp_valid, 1);
    if (exp_lat > 0) check("rsp_latency", n, exp_lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_status", rsp_status, est);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    e = exp_q.pop_front();
    check("rsp_status", rsp_status, e[129:128]);
    check("rsp_data", rsp_data, e[127:0]);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("b2b_cmd_ready", cmd_ready, 1);
    check("post_rsp_valid", rsp_valid, 0);
    check("post_rsp_data", rsp_data, 0);
    if (no_req) check("no_mem_req", req_cnt, 0);
    if (op == 2'b00) check("writes_left", wr_exp.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] d1, d2, d3;
    d1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    d2 = {$urandom, $urandom, $urandom, $urandom};
    d3 = {$urandom, $urandom, $urandom, $urandom};
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_slot = '0; cmd_data = '0;
    rsp_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    gnt_tied = 1'b1; dly_rand = 1'b0;
    do_cmd(2'b00, 4'd3, d1, ST_OK, '0, 5, 0, 1'b0);
    do_cmd(2'b01, 4'd3, '0, ST_OK, d1, 6, 0, 1'b0);

    gnt_tied = 1'b0; dly_rand = 1'b1;
    repeat (3) do_cmd(2'b01, 4'd3, '0, ST_OK, d1, -1, 0, 1'b0);
    do_cmd(2'b01, 4'd7, '0, ST_EMPTY, '0, 1, 0, 1'b1);
    do_cmd(2'b10, 4'd3, '0, ST_OK, '0, 1, 0, 1'b1);
    do_cmd(2'b01, 4'd3, '0, ST_EMPTY, '0, 1, 0, 1'b1);
    do_cmd(2'b00, 4'd5, d2, ST_OK, '0, -1, 0, 1'b0);
    do_cmd(2'b01, 4'd5, '0, ST_OK, d2, -1, 0, 1'b0);
    do_cmd(2'b10, 4'd9, '0, ST_OK, '0, 1, 0, 1'b1);
    do_cmd(2'b11, 4'd2, '0, ST_UNK_CMD, '0, 1, 5, 1'b1);

    // Reset lands after the second write beat has been granted.
    gnt_tied = 1'b1; dly_rand = 1'b0;
    @(negedge clk);
    wr_exp.push_back('{addr: 6'd12, data: d3[31:0]});
    wr_exp.push_back('{addr: 6'd13, data: d3[63:32]});
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_slot = 4'd3; cmd_data = d3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset("midrst");
    check("midrst_writes", wr_exp.size(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_cmd(2'b01, 4'd3, '0, ST_EMPTY, '0, 1, 0, 1'b1);
    do_cmd(2'b01, 4'd5, '0, ST_EMPTY, '0, 1, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
